// File: rtl/mix_keystream_ctrl_if.sv
// -----------------------------------------------------------------------------
// mix_keystream_ctrl_if
//   Groups the generator/mixer handshake and the two pixel streams that the
//   keystream controller sits between.
//
//   Signals (direction as seen from the controller, modport master):
//     gen_step      out  1  one-cycle pulse: chaos generators advance one step
//     gen_done      in   1  one-cycle pulse: generator outputs updated/stable
//     mix_v         in   8  3-input XOR mixer output byte
//     pix_in_valid  in   1  plaintext byte valid
//     pix_in_ready  out  1  controller accepts plaintext byte
//     pix_in_data   in   8  plaintext byte
//     pix_out_valid out  1  ciphertext byte valid
//     pix_out_ready in   1  downstream accepts ciphertext byte
//     pix_out_data  out  8  ciphertext byte
//   Modport slave is the mirror view used by the generator/FIFO side.
// -----------------------------------------------------------------------------
interface mix_keystream_ctrl_if;
  logic       gen_step;
  logic       gen_done;
  logic [7:0] mix_v;
  logic       pix_in_valid;
  logic       pix_in_ready;
  logic [7:0] pix_in_data;
  logic       pix_out_valid;
  logic       pix_out_ready;
  logic [7:0] pix_out_data;

  modport master (
    output gen_step, pix_in_ready, pix_out_valid, pix_out_data,
    input  gen_done, mix_v, pix_in_valid, pix_in_data, pix_out_ready
  );

  modport slave (
    input  gen_step, pix_in_ready, pix_out_valid, pix_out_data,
    output gen_done, mix_v, pix_in_valid, pix_in_data, pix_out_ready
  );
endinterface

// File: rtl/mix_keystream_ctrl.sv
// -----------------------------------------------------------------------------
// mix_keystream_ctrl
//   Sequences the chaos-map generators and the XOR byte mixer so that exactly
//   one keystream byte is produced per pixel, XORs it onto a valid/ready pixel
//   stream, counts pixels and pulses done at the end of a frame.
//
//   Parameters:
//     N_PIXELS  pixels per frame (>=1)
//     CNT_W     pixel counter width, must hold N_PIXELS-1
//     MIX_LAT   mixer latency from generator outputs to mix_v (>=1)
//
//   Ports:
//     clk      in   1      system clock
//     rst      in   1      synchronous, active-high reset
//     start    in   1      begin a frame (sampled only while idle)
//     iv       in   8      initial chaining byte, sampled with start
//     busy     out  1      high whenever the controller is not idle
//     done     out  1      one-cycle pulse after the last pixel leaves
//     pix_idx  out  CNT_W  index of the pixel currently in progress
//     bus      master modport of mix_keystream_ctrl_if (generator + pixels)
//
//   Build option:
//     DIFFUSION_EN  defined   : cipher = p ^ key ^ chain, chain follows the
//                               ciphertext (seeded by iv)
//                   undefined : cipher = p ^ key, iv unused
// -----------------------------------------------------------------------------
module mix_keystream_ctrl #(
  parameter int N_PIXELS = 65536,
  parameter int CNT_W    = 17,
  parameter int MIX_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           iv,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pix_idx,
  mix_keystream_ctrl_if.master bus
);

  localparam int MCNT_W = $clog2(MIX_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT_GEN,
    S_MIX,
    S_WAIT_PIX,
    S_OUT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MCNT_W-1:0]  r_mcnt;
  logic [7:0]         r_key;
  logic [7:0]         r_pix_out;
  logic [CNT_W-1:0]   r_pix_idx;
  logic [7:0]         w_cipher;
  logic               w_mix_last;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_last_pix;

  // mcnt counts MIX cycles from 0; the key is the mixer output in the
  // MIX_LAT-th cycle after gen_done.
  assign w_mix_last = (r_mcnt == MCNT_W'(MIX_LAT - 1));
  assign w_in_hs    = (r_state == S_WAIT_PIX) && bus.pix_in_valid;
  assign w_out_hs   = (r_state == S_OUT) && bus.pix_out_ready;
  assign w_last_pix = (r_pix_idx == CNT_W'(N_PIXELS - 1));

`ifdef DIFFUSION_EN
  logic [7:0] r_chain;

  assign w_cipher = bus.pix_in_data ^ r_key ^ r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= 8'h00;
    end else if (r_state == S_IDLE && start) begin
      r_chain <= iv;
    end else if (w_out_hs) begin
      // Ciphertext chaining: the byte just accepted seeds the next pixel.
      r_chain <= r_pix_out;
    end
  end
`else
  logic w_unused_iv;

  assign w_cipher    = bus.pix_in_data ^ r_key;
  assign w_unused_iv = ^iv;
`endif

  // State register and datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcnt    <= '0;
      r_key     <= 8'h00;
      r_pix_out <= 8'h00;
      r_pix_idx <= '0;
    end else begin
      r_state <= w_next;

      // Counter is held at 0 outside MIX so entering MIX always starts at 0.
      if (r_state == S_MIX) begin
        r_mcnt <= r_mcnt + MCNT_W'(1);
      end else begin
        r_mcnt <= '0;
      end

      if (r_state == S_MIX && w_mix_last) begin
        r_key <= bus.mix_v;
      end

      if (w_in_hs) begin
        r_pix_out <= w_cipher;
      end

      if (r_state == S_IDLE && start) begin
        r_pix_idx <= '0;
      end else if (w_out_hs && !w_last_pix) begin
        r_pix_idx <= r_pix_idx + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // can be inferred when a case branch leaves w_next untouched.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start)            w_next = S_STEP;
      S_STEP:                           w_next = S_WAIT_GEN;
      S_WAIT_GEN: if (bus.gen_done)     w_next = S_MIX;
      S_MIX:      if (w_mix_last)       w_next = S_WAIT_PIX;
      S_WAIT_PIX: if (w_in_hs)          w_next = S_OUT;
      S_OUT:      if (w_out_hs)         w_next = w_last_pix ? S_DONE : S_STEP;
      S_DONE:                           w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  // All control outputs are pure state decodes, so they are 0 in IDLE/reset
  // and each ready/valid can only be high in its own state.
  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_DONE);
  assign bus.gen_step      = (r_state == S_STEP);
  assign bus.pix_in_ready  = (r_state == S_WAIT_PIX);
  assign bus.pix_out_valid = (r_state == S_OUT);
  assign bus.pix_out_data  = r_pix_out;
  assign pix_idx           = r_pix_idx;

endmodule

// File: tb/tb_mix_keystream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mix_keystream_ctrl
//   Self-checking bench for mix_keystream_ctrl (small frame, N_PIXELS=4).
//   Plays the generator, mixer and both pixel FIFOs with randomized timing and
//   data; expected ciphertext is p ^ key (^ chain with DIFFUSION_EN), where
//   key is whatever the mixer presented MIX_LAT cycles after gen_done.
// -----------------------------------------------------------------------------
module tb_mix_keystream_ctrl;
  localparam int N_PIX   = 4;
  localparam int CNT_W   = 3;
  localparam int MIX_LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       iv;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pix_idx;

  mix_keystream_ctrl_if bus ();

  mix_keystream_ctrl #(
    .N_PIXELS (N_PIX),
    .CNT_W    (CNT_W),
    .MIX_LAT  (MIX_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .iv      (iv),
    .busy    (busy),
    .done    (done),
    .pix_idx (pix_idx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         gen_steps;
  logic [7:0] m_chain;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full pixel: STEP .. OUT handshake. Called in the window where
  // gen_step is expected (or shortly before it).
  task automatic do_pixel(input int idx, input bit last, input int stall,
                          input bit spur_gd, input bit start_in_wait,
                          input bit start_in_done);
    logic [7:0] key;
    logic [7:0] p;
    logic [7:0] exp_out;
    bit         seen;
    int         n;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (bus.gen_step === 1'b1) seen = 1'b1;
      else tick();
    end
    check("gen_step_seen", 32'(seen), 32'd1);
    if (!seen) return;
    gen_steps++;
    check("pix_idx_step", 32'(pix_idx), 32'(idx));
    key = 8'($urandom);
    bus.mix_v = key ^ 8'($urandom_range(1, 255));
    // A gen_done during STEP must be ignored.
    bus.gen_done = spur_gd;
    tick();
    bus.gen_done = 1'b0;
    check("gen_step_pulse", 32'(bus.gen_step), 32'd0);
    n = $urandom_range(0, 3);
    repeat (n) begin
      tick();
      check("ready_wait_gen", 32'(bus.pix_in_ready), 32'd0);
    end
    // Cycle T: gen_done. The mixer shows the key only in cycle T+MIX_LAT.
    bus.gen_done = 1'b1;
    for (int k = 1; k <= MIX_LAT; k++) begin
      tick();
      bus.gen_done = 1'b0;
      bus.mix_v = (k == MIX_LAT) ? key : (key ^ 8'($urandom_range(1, 255)));
      check("ready_before_key", 32'(bus.pix_in_ready), 32'd0);
    end
    tick();
    bus.mix_v = key ^ 8'($urandom_range(1, 255));
    check("ready_first", 32'(bus.pix_in_ready), 32'd1);
    check("pix_idx_wait", 32'(pix_idx), 32'(idx));
    if (start_in_wait) start = 1'b1;
    n = $urandom_range(0, 2);
    repeat (n) begin
      tick();
      start = 1'b0;
      check("ready_hold", 32'(bus.pix_in_ready), 32'd1);
    end
    p = 8'($urandom);
    bus.pix_in_valid = 1'b1;
    bus.pix_in_data  = p;
    exp_out = p ^ key;
`ifdef DIFFUSION_EN
    exp_out = exp_out ^ m_chain;
`endif
    tick();
    start = 1'b0;
    bus.pix_in_valid = 1'b0;
    bus.pix_in_data  = 8'($urandom);
    check("out_valid", 32'(bus.pix_out_valid), 32'd1);
    check("out_data", 32'(bus.pix_out_data), 32'(exp_out));
    check("ready_in_out", 32'(bus.pix_in_ready), 32'd0);
    bus.pix_out_ready = 1'b0;
    repeat (stall) begin
      tick();
      check("stall_valid", 32'(bus.pix_out_valid), 32'd1);
      check("stall_data", 32'(bus.pix_out_data), 32'(exp_out));
      check("stall_gen_step", 32'(bus.gen_step), 32'd0);
      check("stall_in_ready", 32'(bus.pix_in_ready), 32'd0);
    end
    bus.pix_out_ready = 1'b1;
    tick();
    bus.pix_out_ready = 1'b0;
    m_chain = exp_out;
    check("out_valid_drop", 32'(bus.pix_out_valid), 32'd0);
    check("done_pulse", 32'(done), 32'(last));
    if (last) begin
      check("busy_in_done", 32'(busy), 32'd1);
      if (start_in_done) start = 1'b1;
      tick();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      check("pix_idx_held", 32'(pix_idx), 32'(N_PIX - 1));
    end
  endtask

  // Whole frame, started from an IDLE window.
  task automatic run_frame(input bit directed);
    logic [7:0] f_iv;
    int         stall;
    f_iv  = 8'($urandom);
    iv    = f_iv;
    start = 1'b1;
    tick();
    start   = 1'b0;
    iv      = 8'($urandom);
    m_chain = f_iv;
    check("busy_after_start", 32'(busy), 32'd1);
    check("pix_idx_start", 32'(pix_idx), 32'd0);
    gen_steps = 0;
    for (int idx = 0; idx < N_PIX; idx++) begin
      stall = (directed && idx == 2) ? 5 : $urandom_range(0, 3);
      do_pixel(idx, idx == N_PIX - 1, stall, directed && idx == 1,
               directed && idx == 1, directed);
    end
    check("gen_step_count", 32'(gen_steps), 32'(N_PIX));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    iv = 8'h00;
    bus.gen_done = 1'b0;
    bus.mix_v = 8'h00;
    bus.pix_in_valid = 1'b0;
    bus.pix_in_data = 8'h00;
    bus.pix_out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gen_step", 32'(bus.gen_step), 32'd0);
    check("rst_in_ready", 32'(bus.pix_in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.pix_out_valid), 32'd0);
    check("rst_out_data", 32'(bus.pix_out_data), 32'd0);
    check("rst_pix_idx", 32'(pix_idx), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Frame with spurious gen_done in STEP, start pulses in WAIT_PIX and DONE,
    // and a 5-cycle output stall; then a back-to-back frame started in the
    // cycle right after done.
    run_frame(1'b1);
    run_frame(1'b0);
    tick();
    run_frame(1'b0);

    // Reset in the middle of OUT aborts the frame without a done pulse.
    iv = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (bus.pix_in_ready === 1'b1) seen = 1'b1;
      else tick();
    end
    check("abort_ready_seen", 32'(seen), 32'd1);
    bus.pix_in_valid = 1'b1;
    tick();
    bus.pix_in_valid = 1'b0;
    check("abort_in_out", 32'(bus.pix_out_valid), 32'd1);
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(bus.pix_out_valid), 32'd0);
      check("abort_pix_idx", 32'(pix_idx), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd0);

    // Recovery frame after the abort.
    run_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
